// File: rtl/axi4l_reg_pkg.sv
// axi4l_reg_pkg: shared response codes, FSM state types and byte-strobe merge helper
package axi4l_reg_pkg;
    localparam logic [1:0] AXI_RESP_OKAY_C   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR_C = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} write_state_t;
    typedef enum logic {R_IDLE, R_DATA} read_state_t;

    function automatic logic [63:0] strb_merge(input logic [63:0] old_v, input logic [63:0] new_v, input logic [7:0] strb);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        return r;
    endfunction
endpackage

// File: rtl/axi4l_reg_decoder.sv
// axi4l_reg_decoder: maps a word address onto the control bank, status bank or nothing
module axi4l_reg_decoder
    import axi4l_reg_pkg::*;
#(
    parameter int WA    = 14,
    parameter int NR_CR = 8,
    parameter int NR_SR = 8,
    parameter int IW    = 3
) (
    input  logic [WA-1:0] word,
    output logic          is_cr,
    output logic          is_sr,
    output logic [IW-1:0] index
);
    localparam logic [WA-1:0] CR_N   = WA'(NR_CR);
    localparam logic [WA-1:0] SR_END = WA'(NR_CR + NR_SR);

    always_comb begin
        is_cr = word < CR_N;
        is_sr = !is_cr && word < SR_END;
        index = is_sr ? IW'(word - CR_N) : IW'(word);
    end
endmodule

// File: rtl/axi4l_reg_bank.sv
// axi4l_reg_bank: AXI4-Lite slave with read/write control registers and read-only status registers
module axi4l_reg_bank
    import axi4l_reg_pkg::*;
#(
    parameter int AXI_DATA_WIDTH_C = 32,
    parameter int AXI_ADDR_WIDTH_C = 16,
    parameter int NR_OF_CR_C       = 8,
    parameter int NR_OF_SR_C       = 8,
    parameter logic [NR_OF_CR_C-1:0] CMD_MASK_C = '0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [AXI_ADDR_WIDTH_C-1:0]          awaddr,
    input  logic                                 awvalid,
    output logic                                 awready,
    input  logic [AXI_DATA_WIDTH_C-1:0]          wdata,
    input  logic [AXI_DATA_WIDTH_C/8-1:0]        wstrb,
    input  logic                                 wvalid,
    output logic                                 wready,
    output logic [1:0]                           bresp,
    output logic                                 bvalid,
    input  logic                                 bready,
    input  logic [AXI_ADDR_WIDTH_C-1:0]          araddr,
    input  logic                                 arvalid,
    output logic                                 arready,
    output logic [AXI_DATA_WIDTH_C-1:0]          rdata,
    output logic [1:0]                           rresp,
    output logic                                 rvalid,
    input  logic                                 rready,
    output logic [NR_OF_CR_C*AXI_DATA_WIDTH_C-1:0] cr_q,
    output logic [NR_OF_CR_C-1:0]                cr_wr_pulse,
    input  logic [NR_OF_SR_C*AXI_DATA_WIDTH_C-1:0] sr_d
);
    localparam int DW         = AXI_DATA_WIDTH_C;
    localparam int SW         = DW / 8;
    localparam int ADDR_LSB_C = $clog2(SW);
    localparam int WA         = AXI_ADDR_WIDTH_C - ADDR_LSB_C;
    localparam int MAX_N      = NR_OF_CR_C > NR_OF_SR_C ? NR_OF_CR_C : NR_OF_SR_C;
    localparam int IW         = MAX_N > 1 ? $clog2(MAX_N) : 1;
    localparam int DEPTH      = 2 ** IW;

    write_state_t w_state, w_next;
    read_state_t  r_state, r_next;
    logic          live, aw_held, w_held, aw_hs, w_hs, ar_hs, do_write;
    logic [WA-1:0] aw_addr_q, w_word;
    logic [DW-1:0] w_data_q, w_data, rd_val;
    logic [SW-1:0] w_strb_q, w_strb;
    logic          w_is_cr, r_is_cr, r_is_sr, unused_w_is_sr, unused_lsb;
    logic [IW-1:0] w_idx, r_idx;
    logic [DW-1:0] cr_rb [DEPTH];
    logic [DW-1:0] sr_arr [DEPTH];

    assign unused_lsb = ^{awaddr[ADDR_LSB_C-1:0], araddr[ADDR_LSB_C-1:0]};
    assign aw_hs    = awvalid && awready;
    assign w_hs     = wvalid && wready;
    assign ar_hs    = arvalid && arready;
    // a channel captured in an earlier cycle is served from its holding register
    assign w_word   = aw_held ? aw_addr_q : awaddr[AXI_ADDR_WIDTH_C-1:ADDR_LSB_C];
    assign w_data   = w_held ? w_data_q : wdata;
    assign w_strb   = w_held ? w_strb_q : wstrb;
    assign do_write = w_state == W_IDLE && (aw_held || aw_hs) && (w_held || w_hs);

    axi4l_reg_decoder #(.WA(WA), .NR_CR(NR_OF_CR_C), .NR_SR(NR_OF_SR_C), .IW(IW)) u_w_dec (
        .word (w_word),
        .is_cr(w_is_cr),
        .is_sr(unused_w_is_sr),
        .index(w_idx)
    );

    axi4l_reg_decoder #(.WA(WA), .NR_CR(NR_OF_CR_C), .NR_SR(NR_OF_SR_C), .IW(IW)) u_r_dec (
        .word (araddr[AXI_ADDR_WIDTH_C-1:ADDR_LSB_C]),
        .is_cr(r_is_cr),
        .is_sr(r_is_sr),
        .index(r_idx)
    );

    always_ff @(posedge clk) begin
        w_state <= !rst_n ? W_IDLE : w_next;
        r_state <= !rst_n ? R_IDLE : r_next;
    end

    always_comb begin
        w_next = w_state == W_IDLE ? (do_write ? W_RESP : W_IDLE) : (bready ? W_IDLE : W_RESP);
        r_next = r_state == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) : (rready ? R_IDLE : R_DATA);
    end

    // live keeps the ready outputs low for the whole time reset is held
    always_comb begin
        awready = live && w_state == W_IDLE && !aw_held;
        wready  = live && w_state == W_IDLE && !w_held;
        bvalid  = w_state == W_RESP;
        arready = live && r_state == R_IDLE;
        rvalid  = r_state == R_DATA;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cr_rb[i]  = '0;
            sr_arr[i] = '0;
        end
        for (int i = 0; i < NR_OF_CR_C; i++) cr_rb[i] = CMD_MASK_C[i] ? '0 : cr_q[i*DW +: DW];
        for (int i = 0; i < NR_OF_SR_C; i++) sr_arr[i] = sr_d[i*DW +: DW];
        rd_val = r_is_cr ? cr_rb[r_idx] : r_is_sr ? sr_arr[r_idx] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            live        <= 1'b0;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            bresp       <= AXI_RESP_OKAY_C;
            cr_q        <= '0;
            cr_wr_pulse <= '0;
        end else begin
            live    <= 1'b1;
            aw_held <= !do_write && (aw_held || aw_hs);
            w_held  <= !do_write && (w_held || w_hs);
            if (aw_hs) aw_addr_q <= awaddr[AXI_ADDR_WIDTH_C-1:ADDR_LSB_C];
            if (w_hs) begin
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if (do_write) bresp <= w_is_cr ? AXI_RESP_OKAY_C : AXI_RESP_SLVERR_C;
            for (int i = 0; i < NR_OF_CR_C; i++) begin
                cr_q[i*DW +: DW] <= CMD_MASK_C[i] ? '0 : cr_q[i*DW +: DW];
                cr_wr_pulse[i]   <= 1'b0;
                if (do_write && w_is_cr && w_idx == IW'(i)) begin
                    cr_q[i*DW +: DW] <= DW'(strb_merge(64'(cr_q[i*DW +: DW]), 64'(w_data), 8'(w_strb)));
                    cr_wr_pulse[i]   <= |w_strb;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
            rresp <= AXI_RESP_OKAY_C;
        end else if (ar_hs) begin
            rdata <= rd_val;
            rresp <= (r_is_cr || r_is_sr) ? AXI_RESP_OKAY_C : AXI_RESP_SLVERR_C;
        end
    end
endmodule
